// File: rtl/pwm_timer.sv
// pwm_timer: 16-bit PWM generator / periodic timer with a Wishbone-classic register port.
module pwm_timer #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [3:0]       i_wb_adr,
    input  logic [WIDTH-1:0] i_wb_data,
    output logic             o_wb_ack,
    output logic [WIDTH-1:0] o_wb_data,
    input  logic             i_extclk,
    input  logic [WIDTH-1:0] i_DC,
    input  logic             i_DC_valid,
    output logic             o_pwm
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [6:0]             ctrl_q, ctrl_d;
    logic [WIDTH-1:0]       div_q, div_d, per_q, per_d, dc_q, dc_d, ext_dc_q, ext_dc_d;
    logic [WIDTH-1:0]       presc_q, presc_d, cnt_q, cnt_d, rdata_q, rdata_d, duty;
    logic                   ack_q, ack_d, pwm_q, pwm_d, prev_q, prev_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hit, wr, clr, base_en, tick, wrap, done;

    always_comb begin
        hit      = i_wb_cyc & i_wb_stb & ~ack_q;
        wr       = hit & i_wb_we;
        clr      = wr && i_wb_adr == 4'h0 && i_wb_data[7];
        sync_d   = {sync_q[SYNC_STAGES-2:0], i_extclk};
        prev_d   = sync_q[SYNC_STAGES-1];
        base_en  = ctrl_q[0] ? (sync_q[SYNC_STAGES-1] & ~prev_q) : 1'b1;
        tick     = base_en && (div_q <= ONE || presc_q >= div_q - ONE);
        wrap     = per_q != '0 && cnt_q >= per_q - ONE;
        done     = tick && ctrl_q[2] && wrap && !ctrl_q[1];
        presc_d  = (clr || tick) ? '0 : base_en ? presc_q + ONE : presc_q;
        cnt_d    = (clr || per_q == '0) ? '0 : (tick && ctrl_q[2]) ? (wrap ? '0 : cnt_q + ONE) : cnt_q;
        // A Wishbone write to ctrl overrides the hardware status update in the same cycle
        ctrl_d   = (wr && i_wb_adr == 4'h0) ? i_wb_data[6:0]
                 : done ? {ctrl_q[6], 1'b1, ctrl_q[4:3], ctrl_q[2] & ctrl_q[3], ctrl_q[1:0]}
                 : ctrl_q;
        div_d    = (wr && i_wb_adr == 4'h1) ? i_wb_data : div_q;
        per_d    = (wr && i_wb_adr == 4'h2) ? i_wb_data : per_q;
        dc_d     = (wr && i_wb_adr == 4'h3) ? i_wb_data : dc_q;
        ext_dc_d = i_DC_valid ? i_DC : ext_dc_q;
        duty     = ctrl_q[6] ? ext_dc_q : dc_q;
        pwm_d    = per_q != '0 && ctrl_q[4] && (ctrl_q[1] ? (ctrl_q[2] && cnt_q < duty) : ctrl_q[5]);
        ack_d    = hit;
        rdata_d  = !hit ? rdata_q
                 : i_wb_adr == 4'h0 ? {{(WIDTH-7){1'b0}}, ctrl_q}
                 : i_wb_adr == 4'h1 ? div_q
                 : i_wb_adr == 4'h2 ? per_q
                 : i_wb_adr == 4'h3 ? dc_q
                 : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ctrl_q   <= '0;
            div_q    <= '0;
            per_q    <= '0;
            dc_q     <= '0;
            ext_dc_q <= '0;
            presc_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            ack_q    <= 1'b0;
            pwm_q    <= 1'b0;
            prev_q   <= 1'b0;
            sync_q   <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            div_q    <= div_d;
            per_q    <= per_d;
            dc_q     <= dc_d;
            ext_dc_q <= ext_dc_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            pwm_q    <= pwm_d;
            prev_q   <= prev_d;
            sync_q   <= sync_d;
        end
    end

    assign o_wb_ack  = ack_q;
    assign o_wb_data = rdata_q;
    assign o_pwm     = pwm_q;
endmodule

// File: tb/tb_pwm_timer.sv
// tb_pwm_timer: scoreboard-driven bench for pwm_timer register access, PWM, timer and reset.
module tb_pwm_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [3:0]  wb_adr = '0;
    logic [15:0] wb_wdata = '0;
    logic        wb_ack;
    logic [15:0] wb_rdata;
    logic        extclk = 1'b0;
    logic [15:0] dc_in = '0;
    logic        dc_valid = 1'b0;
    logic        pwm;
    int          n_chk = 0, n_fail = 0;
    int          exp_q[$];

    pwm_timer #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we),
        .i_wb_adr(wb_adr), .i_wb_data(wb_wdata), .o_wb_ack(wb_ack), .o_wb_data(wb_rdata),
        .i_extclk(extclk), .i_DC(dc_in), .i_DC_valid(dc_valid), .o_pwm(pwm)
    );

    always #5 clk = ~clk;

    // Bus driver: returns read data, ack latency in cycles and ack level one cycle later
    task automatic wb_xfer(input logic we, input logic [3:0] a, input logic [15:0] d,
                           output logic [15:0] r, output int lat, output logic ack_after);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = a; wb_wdata = d;
        lat = 0;
        forever begin
            @(posedge clk); #1;
            lat++;
            if (wb_ack === 1'b1 || lat >= 8) break;
        end
        r = wb_rdata;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(posedge clk); #1;
        ack_after = wb_ack;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
        logic [15:0] r; int lat; logic aa;
        wb_xfer(1'b1, a, d, r, lat, aa);
        n_chk++;
        if (lat !== 1 || aa !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_ack adr=%0h: latency %0d ack_after %b, want 1 and 0", a, lat, aa);
        end
    endtask

    task automatic rd_check(input logic [3:0] a, input string nm);
        logic [15:0] r; int lat; logic aa; int e;
        wb_xfer(1'b0, a, 16'h0, r, lat, aa);
        e = exp_q.pop_front();
        n_chk++;
        if (lat !== 1 || r !== 16'(e)) begin
            n_fail++;
            $display("FAIL %s: got %0d (lat %0d), want %0d (lat 1)", nm, r, lat, e);
        end
    endtask

    task automatic run_lengths(output int hi, output int lo);
        int g = 0;
        while (pwm !== 1'b0 && g < 2000) begin @(posedge clk); #1; g++; end
        while (pwm !== 1'b1 && g < 4000) begin @(posedge clk); #1; g++; end
        hi = 0; lo = 0;
        while (pwm === 1'b1 && hi < 2000) begin @(posedge clk); #1; hi++; end
        while (pwm === 1'b0 && lo < 2000) begin @(posedge clk); #1; lo++; end
    endtask

    task automatic high_count(input int n, output int h);
        h = 0;
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; h += (pwm === 1'b1); end
    endtask

    task automatic check_runs(input string nm);
        int hi, lo, eh, el;
        for (int k = 0; k < 2; k++) begin
            run_lengths(hi, lo);
            eh = exp_q.pop_front(); el = exp_q.pop_front();
            n_chk++;
            if (hi !== eh || lo !== el) begin
                n_fail++;
                $display("FAIL %s: high %0d low %0d, want high %0d low %0d", nm, hi, lo, eh, el);
            end
        end
    endtask

    task automatic extpulse(input int n);
        for (int i = 0; i < n; i++) begin
            extclk = 1'b1; repeat (4) @(posedge clk);
            extclk = 1'b0; repeat (4) @(posedge clk);
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (pwm !== 1'b0 || wb_ack !== 1'b0 || wb_rdata !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: pwm %b ack %b data %0h, want 0 0 0", pwm, wb_ack, wb_rdata);
        end
        for (int a = 0; a < 4; a++) begin
            exp_q.push_back(0);
            rd_check(4'(a), "reset_read");
        end
        exp_q.push_back(0);
        rd_check(4'h9, "reset_read_9");
    endtask

    task automatic test_registers();
        wr_reg(4'h2, 16'd100);
        wr_reg(4'h3, 16'd40);
        wr_reg(4'h1, 16'd4);
        wr_reg(4'h9, 16'hBEEF);
        exp_q.push_back(100); rd_check(4'h2, "rd_period");
        exp_q.push_back(40);  rd_check(4'h3, "rd_dc");
        exp_q.push_back(4);   rd_check(4'h1, "rd_divisor");
        exp_q.push_back(0);   rd_check(4'h9, "rd_unmapped");
    endtask

    task automatic test_pwm_reg();
        wr_reg(4'h0, 16'h0016);
        exp_q.push_back(16'h0016); rd_check(4'h0, "rd_ctrl_pwm");
        for (int k = 0; k < 2; k++) begin exp_q.push_back(160); exp_q.push_back(240); end
        check_runs("pwm_reg_runs");
    endtask

    task automatic test_ext_dc();
        dc_in = 16'd50; dc_valid = 1'b1;
        wr_reg(4'h0, 16'h0056);
        for (int k = 0; k < 2; k++) begin exp_q.push_back(200); exp_q.push_back(200); end
        check_runs("pwm_ext_runs");
        dc_valid = 1'b0; dc_in = 16'd10;
        for (int k = 0; k < 2; k++) begin exp_q.push_back(200); exp_q.push_back(200); end
        check_runs("pwm_ext_hold_runs");
    endtask

    task automatic test_edges();
        int h;
        wr_reg(4'h0, 16'h0016);
        wr_reg(4'h3, 16'd0);
        repeat (3) @(posedge clk); #1;
        high_count(400, h);
        n_chk++;
        if (h !== 0) begin n_fail++; $display("FAIL dc_zero: high %0d cycles, want 0", h); end
        wr_reg(4'h3, 16'd150);
        repeat (3) @(posedge clk); #1;
        high_count(400, h);
        n_chk++;
        if (h !== 400) begin n_fail++; $display("FAIL dc_over_period: high %0d cycles, want 400", h); end
        wr_reg(4'h2, 16'd0);
        repeat (3) @(posedge clk); #1;
        high_count(400, h);
        n_chk++;
        if (h !== 0 || dut.cnt_q !== 16'h0) begin
            n_fail++;
            $display("FAIL period_zero: high %0d counter %0d, want 0 and 0", h, dut.cnt_q);
        end
        wr_reg(4'h2, 16'd100);
        wr_reg(4'h3, 16'd40);
        h = 0;
        while (pwm !== 1'b1 && h < 1000) begin @(posedge clk); #1; h++; end
        repeat (20) @(posedge clk);
        #3; rst = 1'b0; #1;
        n_chk++;
        if (pwm !== 1'b0 || h >= 1000) begin
            n_fail++;
            $display("FAIL async_reset_pwm: pwm %b (wait %0d), want 0", pwm, h);
        end
        @(posedge clk); #1; rst = 1'b1;
        for (int a = 0; a < 4; a++) begin
            exp_q.push_back(0);
            rd_check(4'(a), "after_reset_read");
        end
    endtask

    task automatic test_timer_extclk();
        wr_reg(4'h1, 16'd1);
        wr_reg(4'h2, 16'd5);
        wr_reg(4'h0, 16'h0015);
        extpulse(4);
        n_chk++;
        if (pwm !== 1'b0) begin n_fail++; $display("FAIL timer_early: pwm %b after 4 edges, want 0", pwm); end
        exp_q.push_back(16'h0015); rd_check(4'h0, "timer_ctrl_running");
        extpulse(1);
        repeat (2) @(posedge clk); #1;
        n_chk++;
        if (pwm !== 1'b1) begin n_fail++; $display("FAIL timer_done_pwm: pwm %b, want 1", pwm); end
        exp_q.push_back(16'h0031); rd_check(4'h0, "timer_ctrl_done");
        wr_reg(4'h0, 16'h0010);
        repeat (2) @(posedge clk); #1;
        n_chk++;
        if (pwm !== 1'b0) begin n_fail++; $display("FAIL timer_clear_pwm: pwm %b, want 0", pwm); end
        exp_q.push_back(16'h0010); rd_check(4'h0, "timer_ctrl_cleared");
    endtask

    initial begin
        test_reset();
        test_registers();
        test_pwm_reg();
        test_ext_dc();
        test_edges();
        test_timer_extclk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_timer.md
Name: pwm_timer

Overview:
- 16-bit PWM generator / periodic timer with a Wishbone-classic slave register interface.
- The count base is either the system clock or a synchronized external clock, divided by a programmable prescaler.
- The duty cycle comes from a Wishbone register or from a validated external input bus.
- Drives a single o_pwm pin.

Parameters:
- WIDTH, 16, width of data bus, counter, period, duty and divisor registers.
- SYNC_STAGES, 2, synchronizer flops on i_extclk.

Ports:
- i_clk  input  1  system clock; the only clock domain; all logic on rising edge.
- i_rst  input  1  reset, asynchronous, active-low (0 = reset).
- i_wb_cyc  input  1  Wishbone cycle.
- i_wb_stb  input  1  Wishbone strobe.
- i_wb_we  input  1  1 = write, 0 = read.
- i_wb_adr  input  4  register address.
- i_wb_data  input  16  write data.
- o_wb_ack  output  1  transfer acknowledge.
- o_wb_data  output  16  read data.
- i_extclk  input  1  external count clock; treated as asynchronous data, sampled by i_clk.
- i_DC  input  16  external duty-cycle value.
- i_DC_valid  input  1  qualifies i_DC.
- o_pwm  output  1  PWM / timer output.

Behaviour:
- Reset (i_rst=0, async): all registers, prescaler, counter, ext-DC latch, o_wb_ack, o_wb_data and o_pwm go to 0.
- Register map, all 16-bit R/W:
  - 0x0 ctrl.
  - 0x1 divisor.
  - 0x2 period.
  - 0x3 dc.
  - Other addresses: writes ignored, reads return 0.
- ctrl bits:
  - [0] clk_sel: 1 = synchronized i_extclk rising edges, 0 = every i_clk.
  - [1] mode_sel: 1 = PWM, 0 = timer.
  - [2] counter_en.
  - [3] continuous: timer mode only.
  - [4] pwm_out_en.
  - [5] period_done: status; set by hardware, cleared by a write of 0.
  - [6] ext_dc_sel.
  - [7] counter_rst: self-clearing.
  - [15:8] reserved, read 0.
- Wishbone:
  - When cyc&stb&!ack, a write updates the register at that edge, and o_wb_ack=1 for exactly one cycle on the next cycle.
  - Read data is registered with the ack.
  - ack drops the following cycle even if stb is still held; a held strobe produces a new ack every other cycle.
  - One-cycle latency, no wait states.
- Base enable:
  - clk_sel=0: every cycle.
  - clk_sel=1: one cycle per rising edge of i_extclk after the SYNC_STAGES synchronizer plus edge detect.
- Prescaler:
  - Counts base enables 0..divisor-1.
  - Emits tick when it reaches divisor-1, then wraps to 0.
  - divisor 0 or 1 means tick on every base enable.
- Counter:
  - Advances on tick while counter_en=1; holds while counter_en=0.
  - Wraps from period-1 to 0.
  - period=0 holds the counter at 0.
  - Writing ctrl[7]=1 clears the prescaler and counter that cycle; bit 7 reads back 0.
- Effective duty:
  - ext_dc_sel=1: the ext-DC latch, which loads i_DC on any cycle with i_DC_valid=1 and otherwise holds.
  - ext_dc_sel=0: the dc register.
  - Register/latch changes take effect immediately in the compare.
- PWM mode, with counter_en=1 and pwm_out_en=1:
  - o_pwm = (counter < effective duty), registered (1 cycle after the counter).
  - duty=0 gives constant 0.
  - duty>=period (period>0) gives constant 1.
- Timer mode:
  - On tick at counter==period-1, set period_done.
  - o_pwm = pwm_out_en & period_done.
  - If continuous=0, counter_en is cleared by hardware at that point; if continuous=1, the counter wraps and keeps running.
- o_pwm=0 whenever pwm_out_en=0, counter_en=0 (PWM mode), or period=0.
- Simultaneous hardware set of period_done and a Wishbone write to ctrl: the Wishbone write wins.

Test Plan:
- Reset: release i_rst to 1.
  - All outputs are 0.
  - Reading 0x0–0x3 returns 0.
  - Reading 0x9 returns 0.
- Register access: write period=100 (0x2), dc=40 (0x3), divisor=4 (0x1).
  - Each write gets a one-cycle ack one cycle after the strobe.
  - Readback returns 100/40/4.
  - Reading 0x9 returns 0.
- PWM from register: write ctrl=0x0016.
  - o_pwm is high 160 clk and low 240 clk per 400-clk period, repeating.
- External duty: i_DC=50, i_DC_valid=1, then write ctrl=0x0056.
  - High time becomes 200 clk of 400.
  - Dropping i_DC_valid and changing i_DC to 10 leaves the high time at 200 clk.
- Edges:
  - dc=0: o_pwm constant 0.
  - dc=150 with period=100: o_pwm constant 1.
  - period=0: o_pwm 0 and counter stuck at 0.
  - Driving i_rst low mid-period clears o_pwm asynchronously and zeroes all registers.
- Timer and external clock: ctrl=0x0015 (extclk, timer, enable, out_en), period=5, divisor=1.
  - After 5 synchronized extclk edges, period_done=1, o_pwm=1 and counter_en reads back 0.
  - Writing ctrl=0x0010 clears period_done and o_pwm.
